// File: rtl/seg7_multi_driver_if.sv
// Bus bundle for seg7_multi_driver: load-side controls and registered display outputs.
// The driver module takes the slave modport; the producing logic or testbench takes the master modport.
interface seg7_multi_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    LOAD;
  logic [4*NUM_DIGITS-1:0] VALUE;
  logic [NUM_DIGITS-1:0]   DIG_EN;
  logic [NUM_DIGITS-1:0]   BLINK_EN;
  logic [NUM_DIGITS-1:0]   DP_IN;
  logic [7*NUM_DIGITS-1:0] SEGS;
  logic [NUM_DIGITS-1:0]   DP;
  logic                    BLINK_PHASE;

  modport master (
    output LOAD, VALUE, DIG_EN, BLINK_EN, DP_IN,
    input  SEGS, DP, BLINK_PHASE
  );

  modport slave (
    input  LOAD, VALUE, DIG_EN, BLINK_EN, DP_IN,
    output SEGS, DP, BLINK_PHASE
  );
endinterface

// File: rtl/seg7_multi_driver.sv
// Registered multi-digit hex 7-segment driver with per-digit enable, blink and DP.
// Optional leading-zero blanking is compiled in when SEG7_LZB_EN is defined.
module seg7_multi_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int BLINK_DIV  = 25000000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  seg7_multi_driver_if.slave    bus
);

  localparam int CW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);
  localparam logic [7*NUM_DIGITS-1:0] SEG_BLANK = ACTIVE_LOW ? '1 : '0;
  localparam logic [NUM_DIGITS-1:0]   DP_BLANK  = ACTIVE_LOW ? '1 : '0;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      default: pat = 7'h71;
    endcase
    return pat;
  endfunction

  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   dig_en_q, dig_en_d;
  logic [NUM_DIGITS-1:0]   blink_en_q, blink_en_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    phase_q, phase_d;
  logic [7*NUM_DIGITS-1:0] segs_q, segs_d;
  logic [NUM_DIGITS-1:0]   dp_out_q, dp_out_d;

  logic [NUM_DIGITS-1:0]   supp;

  // Shadow registers and blink timebase
  always_comb begin
    value_d    = value_q;
    dig_en_d   = dig_en_q;
    blink_en_d = blink_en_q;
    dp_d       = dp_q;
    cnt_d      = cnt_q + CW'(1);
    phase_d    = phase_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
    if (bus.LOAD) begin
      value_d    = bus.VALUE;
      dig_en_d   = bus.DIG_EN;
      blink_en_d = bus.BLINK_EN;
      dp_d       = bus.DP_IN;
      // A newly blinking digit must start in its visible half; this also overrides a wrap.
      if (|bus.BLINK_EN) begin
        cnt_d   = '0;
        phase_d = 1'b0;
      end
    end
  end

`ifdef SEG7_LZB_EN
  always_comb begin
    logic run;
    supp = '0;
    run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      run     = run && (value_q[4*i +: 4] == 4'h0) && !dp_q[i];
      supp[i] = run;
    end
  end
`else
  assign supp = '0;
`endif

  wire [6:0] pat_w [NUM_DIGITS];
  wire       dpl_w [NUM_DIGITS];

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      wire lit = dig_en_q[gi] && !(blink_en_q[gi] && phase_q) && !supp[gi];
      assign pat_w[gi] = lit ? hex_decode(value_q[4*gi +: 4]) : 7'h00;
      assign dpl_w[gi] = lit && dp_q[gi];
    end
  endgenerate

  // Polarity is applied ahead of the output register so pins never glitch.
  always_comb begin
    segs_d   = '0;
    dp_out_d = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      segs_d[7*i +: 7] = ACTIVE_LOW ? ~pat_w[i] : pat_w[i];
      dp_out_d[i]      = ACTIVE_LOW ? ~dpl_w[i] : dpl_w[i];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      value_q    <= '0;
      dig_en_q   <= '0;
      blink_en_q <= '0;
      dp_q       <= '0;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      segs_q     <= SEG_BLANK;
      dp_out_q   <= DP_BLANK;
    end else begin
      value_q    <= value_d;
      dig_en_q   <= dig_en_d;
      blink_en_q <= blink_en_d;
      dp_q       <= dp_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      segs_q     <= segs_d;
      dp_out_q   <= dp_out_d;
    end
  end

  assign bus.SEGS        = segs_q;
  assign bus.DP          = dp_out_q;
  assign bus.BLINK_PHASE = phase_q;

endmodule

// File: tb/tb_seg7_multi_driver.sv
// Self-checking bench for seg7_multi_driver: directed plan cases plus random loads,
// compared every cycle against a cycle-count based reference model.
module tb_seg7_multi_driver;
  localparam int ND = 4;
  localparam int BD = 4;
  localparam bit AL = 1'b1;

  logic CLK = 1'b0;
  logic RST;

  seg7_multi_driver_if #(.NUM_DIGITS(ND)) bus ();

  seg7_multi_driver #(.NUM_DIGITS(ND), .BLINK_DIV(BD), .ACTIVE_LOW(AL)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference state: latched controls and the edge at which the blink count last restarted.
  logic [15:0] m_val;
  logic [3:0]  m_en, m_be, m_dp;
  int          edge_n = 0;
  int          t0     = 0;
  bit          m_phase;

  function automatic void model_view(output logic [27:0] s, output logic [3:0] d);
    bit         run;
    bit         supp;
    bit         lit;
    logic [3:0] nib;
    run = 1'b1;
    s   = '0;
    d   = '0;
    for (int i = ND - 1; i >= 0; i--) begin
      nib  = m_val[4*i +: 4];
      supp = 1'b0;
`ifdef SEG7_LZB_EN
      if (i > 0 && run && nib == 4'h0 && !m_dp[i]) supp = 1'b1;
      else run = 1'b0;
`endif
      lit = m_en[i] && !(m_be[i] && m_phase) && !supp;
      s[7*i +: 7] = lit ? ~tbl[nib] : 7'h7F;
      d[i]        = lit ? ~m_dp[i] : 1'b1;
    end
  endfunction

  // One clock: drive at negedge, advance model, check at the following negedge.
  task automatic cycle(input bit ld, input logic [15:0] v, input logic [3:0] en,
                       input logic [3:0] be, input logic [3:0] dp);
    logic [27:0] es;
    logic [3:0]  ed;
    bus.LOAD     = ld;
    bus.VALUE    = v;
    bus.DIG_EN   = en;
    bus.BLINK_EN = be;
    bus.DP_IN    = dp;
    model_view(es, ed);
    edge_n++;
    if (ld) begin
      m_val = v; m_en = en; m_be = be; m_dp = dp;
      if (be != 4'h0) t0 = edge_n;
    end
    m_phase = (((edge_n - t0) / BD) % 2) == 1;
    @(posedge CLK);
    @(negedge CLK);
    check_eq("segs", {4'h0, bus.SEGS}, {4'h0, es});
    check_eq("dp", {28'h0, bus.DP}, {28'h0, ed});
    check_eq("phase", {31'h0, bus.BLINK_PHASE}, {31'h0, m_phase});
    $display("cyc %0d ld=%0b val=%h en=%h be=%h dp=%h -> segs=%h dp=%h ph=%0b",
             edge_n, ld, v, en, be, dp, bus.SEGS, bus.DP, bus.BLINK_PHASE);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 4'h0, 4'h0, 4'h0);
  endtask

  task automatic reset_model();
    m_val = '0; m_en = '0; m_be = '0; m_dp = '0;
    m_phase = 1'b0;
    t0 = edge_n;
  endtask

  // Asynchronous reset landing between clock edges.
  task automatic mid_reset();
    #2 RST = 1'b1;
    #1;
    check_eq("rst_segs", {4'h0, bus.SEGS}, 32'h0FFFFFFF);
    check_eq("rst_dp", {28'h0, bus.DP}, 32'hF);
    check_eq("rst_phase", {31'h0, bus.BLINK_PHASE}, 32'h0);
    $display("async reset applied at edge %0d", edge_n);
    @(negedge CLK);
    RST = 1'b0;
    reset_model();
  endtask

  initial begin
    logic [15:0] v;
    logic [3:0]  be;
    RST = 1'b1;
    bus.LOAD = 1'b0; bus.VALUE = '0; bus.DIG_EN = '0; bus.BLINK_EN = '0; bus.DP_IN = '0;
    repeat (3) @(negedge CLK);
    check_eq("reset_segs", {4'h0, bus.SEGS}, 32'h0FFFFFFF);
    check_eq("reset_dp", {28'h0, bus.DP}, 32'hF);
    check_eq("reset_phase", {31'h0, bus.BLINK_PHASE}, 32'h0);
    RST = 1'b0;
    reset_model();
    idle(2);

    // Hex decode with DP on digit 2
    cycle(1'b1, 16'h12AF, 4'hF, 4'h0, 4'b0100);
    idle(1);
    check_eq("plan_12af_segs", {4'h0, bus.SEGS}, {4'h0, ~7'h06, ~7'h5B, ~7'h77, ~7'h71});
    check_eq("plan_12af_dp", {28'h0, bus.DP}, 32'hB);

    // Enable mask with all DPs requested
    cycle(1'b1, 16'h8888, 4'b1010, 4'h0, 4'hF);
    idle(1);
    check_eq("plan_8888_segs", {4'h0, bus.SEGS}, {4'h0, ~7'h7F, 7'h7F, ~7'h7F, 7'h7F});
    check_eq("plan_8888_dp", {28'h0, bus.DP}, 32'h5);

    // Leading zeros
    cycle(1'b1, 16'h0030, 4'hF, 4'h0, 4'h0);
    idle(1);
`ifdef SEG7_LZB_EN
    check_eq("plan_0030", {4'h0, bus.SEGS}, {4'h0, 7'h7F, 7'h7F, ~7'h4F, ~7'h3F});
`else
    check_eq("plan_0030", {4'h0, bus.SEGS}, {4'h0, ~7'h3F, ~7'h3F, ~7'h4F, ~7'h3F});
`endif
    cycle(1'b1, 16'h0000, 4'hF, 4'h0, 4'h0);
    idle(1);
`ifdef SEG7_LZB_EN
    check_eq("plan_0000", {4'h0, bus.SEGS}, {4'h0, 7'h7F, 7'h7F, 7'h7F, ~7'h3F});
`else
    check_eq("plan_0000", {4'h0, bus.SEGS}, {4'h0, ~7'h3F, ~7'h3F, ~7'h3F, ~7'h3F});
`endif

    // Blink on digit 0: lit 4 cycles, blank 4, lit again
    cycle(1'b1, 16'h5678, 4'hF, 4'b0001, 4'h0);
    idle(4);
    check_eq("blink_lit", {25'h0, bus.SEGS[6:0]}, {25'h0, ~7'h7F});
    idle(4);
    check_eq("blink_hidden", {25'h0, bus.SEGS[6:0]}, 32'h7F);
    idle(4);
    check_eq("blink_relit", {25'h0, bus.SEGS[6:0]}, {25'h0, ~7'h7F});

    // Restart exactly on a wrap edge: no toggle may occur
    cycle(1'b1, 16'h5678, 4'hF, 4'b0001, 4'h0);
    idle(BD - 1);
    cycle(1'b1, 16'h9ABC, 4'hF, 4'b0010, 4'h0);
    check_eq("wrap_restart_phase", {31'h0, bus.BLINK_PHASE}, 32'h0);
    idle(6);
    mid_reset();
    idle(2);

    // Randomized traffic with one more asynchronous reset partway through
    for (int n = 0; n < 300; n++) begin
      v  = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
      be = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      if (n == 150) mid_reset();
      cycle($urandom_range(0, 3) == 0, v, 4'($urandom), be, 4'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/seg7_multi_driver.md
Name: seg7_multi_driver

Overview:
- Registered multi-digit hexadecimal 7-segment display driver.
- Latches a packed NUM_DIGITS x 4-bit value with per-digit enable, blink and decimal-point controls on a load strobe.
- Produces glitch-free registered segment outputs, with a free-running blink timebase.
- Sits between datapath or counter logic and the board's HEXn/DP pins. Replaces per-digit combinational decoders.

Parameters:
- NUM_DIGITS, 4: number of digits driven; legal range 1..8.
- BLINK_DIV, 25000000: blink half-period in CLK cycles; legal range 2..2^26.
- ACTIVE_LOW, 1: 1 means a lit segment/DP drives 0; 0 means a lit segment/DP drives 1.

Ports:
- CLK  in  1  system clock; all state on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- LOAD  in  1  single-cycle strobe; captures VALUE, DIG_EN, BLINK_EN and DP_IN.
- VALUE  in  4*NUM_DIGITS  nibble i = digit i; digit 0 is the least significant (rightmost).
- DIG_EN  in  NUM_DIGITS  1 means digit i is displayed; 0 means digit i is blank.
- BLINK_EN  in  NUM_DIGITS  1 means digit i blinks.
- DP_IN  in  NUM_DIGITS  1 means decimal point i is lit.
- SEGS  out  7*NUM_DIGITS  digit i in bits [7i+6:7i]; bit order g,f,e,d,c,b,a (MSB..LSB).
- DP  out  NUM_DIGITS  decimal point per digit.
- BLINK_PHASE  out  1  current blink phase; 0 = visible, 1 = hidden.

Behaviour:
- Reset (asynchronous, immediate, also mid-operation):
  - Shadow VALUE, DIG_EN, BLINK_EN and DP all 0.
  - Blink counter = 0; BLINK_PHASE = 0.
  - SEGS and DP at the blank level: all 1 if ACTIVE_LOW, else all 0.
- Load:
  - LOAD sampled high at edge k updates the shadow registers at edge k.
  - SEGS/DP reflect the new data from edge k+1, giving a 1-cycle latency.
  - LOAD held for several cycles simply re-latches each cycle.
  - Without LOAD, outputs hold their last latched content; only blink gating changes them.
- Decode, active-high before polarity, hex per nibble 0..F:
  - 0..7: 3F,06,5B,4F,66,6D,7D,07
  - 8..F: 7F,6F,77,7C,39,5E,79,71
  - Lowercase glyphs are used for b and d.
- Digit i is lit only if shadow DIG_EN[i]=1, AND NOT (shadow BLINK_EN[i]=1 AND BLINK_PHASE=1), AND it is not suppressed by LZB (see Optional Feature).
- An unlit digit shows blank segments and a blank DP.
- A lit digit's DP follows shadow DP[i].
- Blink timebase:
  - Counter runs 0..BLINK_DIV-1 continuously.
  - At the edge where the counter equals BLINK_DIV-1, it wraps to 0 and BLINK_PHASE toggles.
  - Resulting period is 2*BLINK_DIV cycles.
- Blink restart: LOAD with any latched BLINK_EN bit set forces counter=0 and BLINK_PHASE=0 at the same edge, so a newly blinking digit starts visible.
  - LOAD has priority over a simultaneous wrap; no toggle occurs that cycle.
  - LOAD with BLINK_EN all 0 leaves the counter running undisturbed.
- Output polarity: if ACTIVE_LOW, SEGS and DP are the bitwise inverse of the active-high pattern; inversion happens before the output register.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: SEG7_LZB_EN (leading-zero blanking).
- With the macro defined:
  - Scanning from digit NUM_DIGITS-1 downward, each digit whose shadow nibble is 0 is suppressed (blank segments and blank DP) until the first nonzero nibble.
  - Digit 0 is never suppressed.
  - A digit with DP[i]=1 stops suppression at that digit and below.
  - Suppression is computed from shadow registers and obeys the same 1-cycle latency.
- Without the macro: no suppression; zeros are displayed as 3F.

Test Plan:
- Reset, then release with no LOAD (NUM_DIGITS=4, ACTIVE_LOW=1) -> SEGS=28'hFFFFFFF, DP=4'hF, BLINK_PHASE=0.
- LOAD at edge k with VALUE=16'h12AF, DIG_EN=4'hF, BLINK_EN=0, DP_IN=4'b0100 -> at edge k+1 digits 3..0 = ~06,~5B,~77,~71 (7-bit); DP=4'b1011.
- BLINK_DIV=4, BLINK_EN=4'b0001, LOAD at cycle 0 -> digit 0 lit cycles 1-4, blank 5-8, lit 9-12; other digits steady; BLINK_PHASE toggles every 4 cycles.
- LOAD with BLINK_EN set on the exact wrap cycle -> counter=0, BLINK_PHASE=0, no toggle; RST asserted mid-blink -> immediate blank outputs and counter=0.
- SEG7_LZB_EN defined, VALUE=16'h0030, DIG_EN=4'hF -> digits 3,2 blank; digit 1 = ~4F; digit 0 = ~3F. VALUE=0 -> only digit 0 shows ~3F. Without the macro, all four digits are shown.
- DIG_EN=4'b1010, VALUE=16'h8888, DP_IN=4'hF -> digits 3,1 = ~7F with DP lit; digits 2,0 fully blank including DP.
